// File: rtl/uart_word_tx_if.sv
// FIFO read-side bundle between the transmit FIFO and the UART word serializer.
// The master drives empty/data (FIFO side); the slave returns the pop strobe.
interface uart_word_tx_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_pop;

  modport master (output fifo_empty, output fifo_data, input fifo_pop);
  modport slave  (input fifo_empty, input fifo_data, output fifo_pop);
endinterface

// File: rtl/uart_word_tx.sv
// UART word serializer: pops a word from a FWFT FIFO and sends it as
// DATA_WIDTH/8 back-to-back 8-bit frames, LSB byte first, optional even parity.
//
// state    | meaning
// S_IDLE   | line high, pop and latch the next word when the FIFO is non-empty
// S_START  | start bit (tx low)
// S_DATA   | 8 data bits of the current byte, LSB first
// S_PARITY | even parity of the current byte (only when PARITY_BIT=1)
// S_STOP   | stop bit; last byte returns to IDLE, otherwise next byte's START
module uart_word_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int PARITY_BIT   = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          uart_clk,
  input  logic          rst_n,
  uart_word_tx_if.slave fifo_if,
  output logic          tx_o,
  output logic          busy_o,
  output logic          word_done_o
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BYTE_W = $clog2(NBYTES) + 1;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [BYTE_W-1:0]     byte_q, byte_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  word_done_q, word_done_d;
  logic                  bit_end;
  logic [7:0]            cur_byte;

  assign bit_end = (cnt_q == CNT_LAST);

  // Gated by rst_n so the FIFO never sees a pop while the block is held in reset.
  assign fifo_if.fifo_pop = rst_n && (state_q == S_IDLE) && !fifo_if.fifo_empty;

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (!fifo_if.fifo_empty) begin
          state_d = S_START;
          shift_d = fifo_if.fifo_data;
          byte_d  = '0;
          bit_d   = '0;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = (PARITY_BIT != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_q == BYTE_LAST) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_START;
            byte_d  = byte_q + 1'b1;
            shift_d = shift_q >> 8;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they describe.
  always_comb begin
    cur_byte = shift_d[7:0];
    tx_d     = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte[bit_d];
      S_PARITY: tx_d = ^cur_byte;
      default:  tx_d = 1'b1;
    endcase
    busy_d      = (state_d != S_IDLE);
    word_done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST) && (byte_d == BYTE_LAST);
  end

  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign word_done_o = word_done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: one instance with parity, one without,
// both at 4 clocks per bit, checked against hand-computed frames.
module tb_uart_word_tx;

  localparam int CPB = 4;

  logic uart_clk = 1'b0;
  logic rst_n;
  logic tx_p, busy_p, wd_p;
  logic tx_n, busy_n, wd_n;

  uart_word_tx_if #(.DATA_WIDTH(32)) if_p ();
  uart_word_tx_if #(.DATA_WIDTH(32)) if_n ();

  uart_word_tx #(.DATA_WIDTH(32), .PARITY_BIT(1), .CLKS_PER_BIT(CPB)) dut_p (
    .uart_clk    (uart_clk),
    .rst_n       (rst_n),
    .fifo_if     (if_p.slave),
    .tx_o        (tx_p),
    .busy_o      (busy_p),
    .word_done_o (wd_p)
  );

  uart_word_tx #(.DATA_WIDTH(32), .PARITY_BIT(0), .CLKS_PER_BIT(CPB)) dut_n (
    .uart_clk    (uart_clk),
    .rst_n       (rst_n),
    .fifo_if     (if_n.slave),
    .tx_o        (tx_n),
    .busy_o      (busy_n),
    .word_done_o (wd_n)
  );

  always #5 uart_clk = ~uart_clk;

  typedef struct {
    logic [31:0] word;
    bit          np;
    logic [7:0]  e0, e1, e2, e3;
    logic [3:0]  ep;
  } vec_t;

  vec_t vecs [4];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit np, input logic [31:0] d, input logic e);
    if (np) begin
      if_n.fifo_data = d; if_n.fifo_empty = e;
    end else begin
      if_p.fifo_data = d; if_p.fifo_empty = e;
    end
  endtask

  function automatic logic tx_of(input bit np);
    return np ? tx_n : tx_p;
  endfunction
  function automatic logic busy_of(input bit np);
    return np ? busy_n : busy_p;
  endfunction
  function automatic logic wd_of(input bit np);
    return np ? wd_n : wd_p;
  endfunction
  function automatic logic pop_of(input bit np);
    return np ? if_n.fifo_pop : if_p.fifo_pop;
  endfunction

  // Called around a negedge with the chosen DUT idle; sends one word and
  // checks every frame, word_done placement, busy and the return to idle.
  task automatic send_check(input vec_t v);
    int         f;
    logic [7:0] eb [4];
    logic       txs [0:175];
    int         wd_cnt, wd_pos, busy_err, hold_err, idle_err;
    f  = v.np ? 10 * CPB : 11 * CPB;
    eb = '{v.e0, v.e1, v.e2, v.e3};
    drive(v.np, v.word, 1'b0);
    #1;
    chk("pop_on_request", pop_of(v.np), 1'b1);
    @(posedge uart_clk);
    #1;
    drive(v.np, ~v.word, 1'b1);
    wd_cnt = 0; wd_pos = -1; busy_err = 0; hold_err = 0;
    for (int i = 0; i < 4 * f; i++) begin
      @(negedge uart_clk);
      txs[i] = tx_of(v.np);
      if (wd_of(v.np)) begin wd_cnt++; wd_pos = i; end
      if (!busy_of(v.np) || pop_of(v.np)) busy_err++;
    end
    for (int i = 0; i < 4 * f; i++) begin
      if (txs[i] !== txs[(i / CPB) * CPB]) hold_err++;
    end
    for (int b = 0; b < 4; b++) begin
      logic [7:0] d;
      int         base;
      base = b * f;
      for (int k = 0; k < 8; k++) d[k] = txs[base + (k + 1) * CPB + 2];
      chk($sformatf("byte%0d_data", b), d, eb[b]);
      chk($sformatf("byte%0d_start", b), txs[base + 2], 1'b0);
      chk($sformatf("byte%0d_stop", b), txs[base + (v.np ? 9 : 10) * CPB + 2], 1'b1);
      if (!v.np) chk($sformatf("byte%0d_parity", b), txs[base + 9 * CPB + 2], v.ep[b]);
    end
    chk("bit_hold_errors", hold_err, 0);
    chk("word_done_count", wd_cnt, 1);
    chk("word_done_cycle", wd_pos, 4 * f - 1);
    chk("busy_window_errors", busy_err, 0);
    idle_err = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge uart_clk);
      if (busy_of(v.np) || !tx_of(v.np) || wd_of(v.np) || pop_of(v.np)) idle_err++;
    end
    chk("idle_after_word", idle_err, 0);
  endtask

  task automatic back_to_back();
    logic [31:0] q [3];
    int idx, pops, last, low, busy_pop, idle_tx_err;
    q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    idx = 0; pops = 0; last = 0; low = 0; busy_pop = 0; idle_tx_err = 0;
    for (int cyc = 0; cyc < 560; cyc++) begin
      @(negedge uart_clk);
      if (idx < 3) drive(1'b0, q[idx], 1'b0);
      else drive(1'b0, 32'h0, 1'b1);
      #1;
      if (!busy_p) begin
        low++;
        if (!tx_p) idle_tx_err++;
      end
      if (if_p.fifo_pop) begin
        pops++;
        if (busy_p) busy_pop++;
        if (pops >= 2) begin
          chk("b2b_pop_period", cyc - last, 4 * 11 * CPB + 1);
          chk("b2b_idle_cycles", low, 1);
        end
        last = cyc;
        low  = 0;
        idx++;
      end
    end
    chk("b2b_pop_count", pops, 3);
    chk("b2b_pop_while_busy", busy_pop, 0);
    chk("b2b_idle_tx_low", idle_tx_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    vecs[0] = '{32'h0000_0001, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 4'b0001};
    vecs[1] = '{32'hA5C3_FF00, 1'b1, 8'h00, 8'hFF, 8'hC3, 8'hA5, 4'b0000};
    vecs[2] = '{32'h1234_5678, 1'b0, 8'h78, 8'h56, 8'h34, 8'h12, 4'b0100};
    vecs[3] = '{32'hFF80_7F03, 1'b0, 8'h03, 8'h7F, 8'h80, 8'hFF, 4'b0110};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'h0, 1'b1);
    repeat (5) @(negedge uart_clk);
    chk("reset_tx", tx_p, 1'b1);
    chk("reset_pop", if_p.fifo_pop, 1'b0);
    chk("reset_busy", busy_p, 1'b0);
    chk("reset_word_done", wd_p, 1'b0);
    chk("reset_tx_noparity", tx_n, 1'b1);
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge uart_clk);
      if (!tx_p || busy_p || wd_p || if_p.fifo_pop || !tx_n || busy_n) act++;
    end
    chk("idle_no_activity", act, 0);

    for (int i = 0; i < 4; i++) begin
      @(negedge uart_clk);
      send_check(vecs[i]);
    end

    @(negedge uart_clk);
    back_to_back();

    // Abort a word in the middle of byte 2 (data bit 1 of 0xAD is 0).
    @(negedge uart_clk);
    drive(1'b0, 32'hDEAD_BEEF, 1'b0);
    @(posedge uart_clk);
    #1;
    drive(1'b0, 32'h0, 1'b1);
    repeat (97) @(negedge uart_clk);
    chk("pre_reset_tx_low", tx_p, 1'b0);
    chk("pre_reset_busy", busy_p, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_tx", tx_p, 1'b1);
    chk("midframe_reset_busy", busy_p, 1'b0);
    repeat (3) @(negedge uart_clk);
    drive(1'b0, 32'h1234_5678, 1'b0);
    #1;
    chk("pop_held_in_reset", if_p.fifo_pop, 1'b0);
    @(negedge uart_clk);
    rst_n = 1'b1;
    send_check(vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Serializing transmit stage of the FPGA_Chess UART link. It drains DATA_WIDTH-bit words from the transmit FIFO's read side and shifts them onto the `tx` line as a sequence of 8-bit UART frames, least-significant byte first. Each frame carries an optional even-parity bit. The block runs entirely in the `uart_clk` domain and generates its own bit timing from a clocks-per-bit divider.

## Interface
- `DATA_WIDTH`, 32: word width. Must be a multiple of 8. NBYTES = DATA_WIDTH/8 frames are sent per word.
- `PARITY_BIT`, 1: 1 appends an even-parity bit after the data bits; 0 sends no parity bit.
- `CLKS_PER_BIT`, 16: `uart_clk` cycles per UART bit. Must be ≥ 2.

- `uart_clk`  in  1  bit-timing and logic clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fifo_empty`  in  1  transmit FIFO read-side empty flag.
- `fifo_data`  in  DATA_WIDTH  FIFO head word (first-word-fall-through); valid whenever `fifo_empty`=0.
- `fifo_pop`  out  1  one-cycle pop strobe. The word on `fifo_data` is consumed on the same edge.
- `tx`  out  1  serial line. Idles high.
- `busy`  out  1  high from the cycle after a pop until the end of the word's last stop bit.
- `word_done`  out  1  one-cycle pulse on the final cycle of the word's last stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If `fifo_empty`=0, assert `fifo_pop` for this cycle, latch `fifo_data` into the shift word, clear the byte counter, go to START.
  - START: `tx`=0 for one bit time, then go to DATA.
  - DATA: 8 bits of the current byte, LSB first, one bit time each. After bit 7, go to PARITY if `PARITY_BIT`=1, else go to STOP.
  - PARITY: `tx` = XOR of the 8 data bits of the current byte (even parity), for one bit time, then go to STOP.
  - STOP: `tx`=1 for one bit time. If byte counter = NBYTES-1, pulse `word_done` and go to IDLE. Otherwise increment the byte counter, shift the word right by 8, and go to START.
- Byte order: `fifo_data[7:0]` first, `fifo_data[DATA_WIDTH-1:DATA_WIDTH-8]` last.
- There is no idle gap between bytes of one word. The next start bit follows the stop bit immediately.
- Between words there is exactly one IDLE cycle with `tx`=1, during which the next pop occurs if the FIFO is non-empty.
- `fifo_pop` is asserted only in IDLE with `fifo_empty`=0. It is never asserted while `busy`=1.
- Counters:
  - The bit-time counter runs 0..CLKS_PER_BIT-1 and reloads to 0 on every state change.
  - The bit index runs 0..7.
  - The byte counter is sized $clog2(NBYTES)+1.
- `fifo_data` changing after the pop has no effect; the word is held internally.

## Timing
- Reset (asynchronous, any state): `tx`=1, `fifo_pop`=0, `busy`=0, `word_done`=0, FSM=IDLE, all counters 0.
  - A reset in mid-frame immediately drives `tx` high and discards the remaining bits of the word.
  - Transmission restarts cleanly from IDLE after rst_n deasserts.
- All outputs are registered, except `fifo_pop`, which is a combinational decode of IDLE && !`fifo_empty`.
- Pop at edge N. Then `busy`=1 and `tx`=0 from N+1.
- Frame length F = (10 + PARITY_BIT) × CLKS_PER_BIT cycles.
- Word length = NBYTES × F cycles, measured from the first start-bit cycle to the last stop-bit cycle inclusive.
- `word_done` is high exactly in the last stop-bit cycle. `busy` falls on the following cycle (IDLE).
- Back-to-back words: with the FIFO non-empty, the next start bit begins 2 cycles after the last stop-bit cycle (the IDLE/pop cycle, then START). Word-to-word period = NBYTES × F + 1 cycles.
- `fifo_empty` rising during a word has no effect. The word in flight always completes.

## Test plan
- Reset idle: hold rst_n low, `fifo_empty`=1 → `tx`=1, `fifo_pop`=0, `busy`=0; no activity for 1000 cycles after release.
- Single word, `CLKS_PER_BIT`=4, `PARITY_BIT`=1, word 0x0000_0001:
  - One `fifo_pop` pulse.
  - Frame 0 on `tx` reads 0,1,0,0,0,0,0,0,0,1,1 (start, data LSB-first, parity=1, stop), each bit held 4 cycles.
  - Frames 1–3 read data 0x00 with parity 0.
  - `word_done` pulses at cycle 4 × 44 = 176 after the first start cycle.
- `PARITY_BIT`=0, word 0xA5C3_FF00: decoded bytes 0x00, 0xFF, 0xC3, 0xA5 in order; each frame is 10 bits (40 cycles at `CLKS_PER_BIT`=4); no parity bit present.
- Back-to-back: preload 3 words, `fifo_empty` held low → pops spaced exactly NBYTES × F + 1 cycles apart; exactly one IDLE cycle (`tx`=1) between words; no pop while `busy`=1.
- Reset mid-frame: assert rst_n during DATA of byte 2 → `tx`=1 within the same cycle and `busy`=0. After release with a new word 0x1234_5678 queued, the decoded output is 0x78, 0x56, 0x34, 0x12 with no residue from the aborted word.
- FIFO empties mid-word: `fifo_empty` rises one cycle after the pop → all NBYTES frames of that word still complete, `word_done` pulses once, then the block stays IDLE.
